zclock_gen: RTL and testbench

- Parametrised Z80 clock generator for the PentEvo top level, running from the 28 MHz system clock.
- Produces `zclk_out` (inverted externally) plus the one-cycle `zpos`/`zneg` pre-strobes used by the memory and port arbiters.
- Generalises speed selection to N binary-divided rates.
- Adds programmable DOS/IO wait-state lengths and a new rule: speed changes take effect only at the next Z80 refresh cycle (falling `rfsh_n`).

---
 rtl/zclock_gen_pkg.sv | 20 ++
 rtl/zclock_gen_if.sv | 38 +++
 rtl/zclock_gen_wait.sv | 56 +++++
 rtl/zclock_gen.sv | 124 ++++++++++++
 tb/tb_zclock_gen.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zclock_gen_pkg.sv
// zclock_pkg: shared constants and helpers for the Z80 clock generator.
// Contents: speed code constants, default wait-state lengths, half-period helper.
// Used by: zclock_gen, zclock_wait and the bench.
package zclock_pkg;

    // Speed codes at a 28 MHz system clock.
    localparam int SPD_3M5 = 0;
    localparam int SPD_7M  = 1;
    localparam int SPD_14M = 2;

    // Default wait-state lengths, in clk cycles.
    localparam int DOS_WAIT_DEF = 4;
    localparam int IO_WAIT_DEF  = 8;

    // Half-period of the Z80 clock in clk cycles for a given speed code.
    function automatic int half_period(input int spd_max, input int spd);
        return 1 << (spd_max - spd);
    endfunction

endpackage

// File: rtl/zclock_gen_if.sv
// zclock_gen_if: bundles the control inputs and clock/strobe outputs of zclock_gen.
// Ports: spd_req, rfsh_n, iorq_s, external_port, dos_on, vdos_off, cpu_stall, ide_stall,
//        dos_wait, io_wait (to the generator); zclk_out, zpos, zneg, spd_cur, stall (from it).
// Modports: master = surrounding logic driving requests, slave = the clock generator.
interface zclock_gen_if #(
    parameter int SPD_W  = 2,
    parameter int WAIT_W = 4
);
    logic [SPD_W-1:0]  spd_req;
    logic              rfsh_n;
    logic              iorq_s;
    logic              external_port;
    logic              dos_on;
    logic              vdos_off;
    logic              cpu_stall;
    logic              ide_stall;
    logic [WAIT_W-1:0] dos_wait;
    logic [WAIT_W-1:0] io_wait;

    logic              zclk_out;
    logic              zpos;
    logic              zneg;
    logic [SPD_W-1:0]  spd_cur;
    logic              stall;

    modport master (
        output spd_req, rfsh_n, iorq_s, external_port, dos_on, vdos_off,
               cpu_stall, ide_stall, dos_wait, io_wait,
        input  zclk_out, zpos, zneg, spd_cur, stall
    );

    modport slave (
        input  spd_req, rfsh_n, iorq_s, external_port, dos_on, vdos_off,
               cpu_stall, ide_stall, dos_wait, io_wait,
        output zclk_out, zpos, zneg, spd_cur, stall
    );

endinterface

// File: rtl/zclock_gen_wait.sv
// zclock_wait: DOS/IO wait-state counter and combined stall generation.
// Ports: clk, rst_n; start strobes (dos_on, vdos_off, iorq_s+external_port), level stalls
//        (cpu_stall, ide_stall), wait lengths (dos_wait, io_wait), spd_cur in; stall out (combinational).
// A start loads the counter (DOS wins, no accumulation); stall covers the start cycle plus the count.
module zclock_wait
    import zclock_pkg::*;
#(
    parameter int SPD_W      = 2,
    parameter int WAIT_W     = 4,
    parameter int IO_SPD_MIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dos_on,
    input  logic              vdos_off,
    input  logic              iorq_s,
    input  logic              external_port,
    input  logic [SPD_W-1:0]  spd_cur,
    input  logic              cpu_stall,
    input  logic              ide_stall,
    input  logic [WAIT_W-1:0] dos_wait,
    input  logic [WAIT_W-1:0] io_wait,
    output logic              stall
);

    logic              dos_start;
    logic              io_start;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    assign dos_start = dos_on | vdos_off;
    // External IO only needs stretching at the fast speeds.
    assign io_start  = iorq_s & external_port & (spd_cur >= SPD_W'(IO_SPD_MIN));

    always_comb begin
        wait_d = wait_q;
        if (dos_start) begin
            wait_d = dos_wait;
        end else if (io_start) begin
            wait_d = io_wait;
        end else if (wait_q != '0) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign stall = cpu_stall | ide_stall | dos_start | io_start | (wait_q != '0);

endmodule

// File: rtl/zclock_gen.sv
// zclock_gen: parametrised Z80 clock generator from the 28 MHz system clock.
// Ports: clk, rst_n, bus (zclock_gen_if.slave: speed request, RFSH, wait-state sources in;
//        zclk_out, zpos/zneg pre-strobes, spd_cur, stall out).
// Optional (ZCLOCK_STALL_STAT_EN): stall_cnt_clr in, stall_cnt[15:0] out, saturating stall-cycle count.
module zclock_gen
    import zclock_pkg::*;
#(
    parameter int SPD_MAX    = 2,
    parameter int SPD_W      = 2,
    parameter int WAIT_W     = 4,
    parameter int IO_SPD_MIN = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    zclock_gen_if.slave  bus
`ifdef ZCLOCK_STALL_STAT_EN
    ,
    input  logic         stall_cnt_clr,
    output logic [15:0]  stall_cnt
`endif
);

    localparam int PH_W = SPD_MAX + 1;

    logic             rfsh_q;
    logic [SPD_W-1:0] spd_cur_q;
    logic [SPD_W-1:0] spd_clamp;
    logic [PH_W-1:0]  phase_q;
    logic [PH_W-1:0]  phase_d;
    logic [PH_W-1:0]  term;
    logic             pre_edge;
    logic             zpos_q;
    logic             zneg_q;
    logic             zclk_q;
    logic             stall;

    zclock_wait #(
        .SPD_W      (SPD_W),
        .WAIT_W     (WAIT_W),
        .IO_SPD_MIN (IO_SPD_MIN)
    ) u_wait (
        .clk           (clk),
        .rst_n         (rst_n),
        .dos_on        (bus.dos_on),
        .vdos_off      (bus.vdos_off),
        .iorq_s        (bus.iorq_s),
        .external_port (bus.external_port),
        .spd_cur       (spd_cur_q),
        .cpu_stall     (bus.cpu_stall),
        .ide_stall     (bus.ide_stall),
        .dos_wait      (bus.dos_wait),
        .io_wait       (bus.io_wait),
        .stall         (stall)
    );

    assign spd_clamp = (bus.spd_req > SPD_W'(SPD_MAX)) ? SPD_W'(SPD_MAX) : bus.spd_req;
    assign term      = PH_W'(half_period(SPD_MAX, int'(spd_cur_q)) - 1);
    assign pre_edge  = (phase_q == term);

    // ">=" also catches a counter left beyond a terminal that just shrank.
    always_comb begin
        phase_d = phase_q;
        if (!stall) begin
            if (phase_q >= term) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfsh_q    <= 1'b1;
            spd_cur_q <= '0;
            phase_q   <= '0;
            zpos_q    <= 1'b0;
            zneg_q    <= 1'b0;
        end else begin
            rfsh_q  <= bus.rfsh_n;
            // Speed only changes on a refresh cycle, so the CPU never sees it mid-access.
            if (rfsh_q && !bus.rfsh_n) begin
                spd_cur_q <= spd_clamp;
            end
            phase_q <= phase_d;
            zpos_q  <= pre_edge & ~stall & zclk_q;
            zneg_q  <= pre_edge & ~stall & ~zclk_q;
        end
    end

    // The clock edge lands half a clk after its strobe, giving arbiters a head start.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zclk_q <= 1'b0;
        end else if (zpos_q) begin
            zclk_q <= 1'b0;
        end else if (zneg_q) begin
            zclk_q <= 1'b1;
        end
    end

    assign bus.zclk_out = zclk_q;
    assign bus.zpos     = zpos_q;
    assign bus.zneg     = zneg_q;
    assign bus.spd_cur  = spd_cur_q;
    assign bus.stall    = stall;

`ifdef ZCLOCK_STALL_STAT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_zclock_gen.sv
// Directed bench for zclock_gen: reset, speed latching on RFSH, clock/strobe timing,
// wait-state stalls, level stalls, reset mid-stall and (with ZCLOCK_STALL_STAT_EN) stall counting.
module tb_zclock_gen;
    import zclock_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

`ifdef ZCLOCK_STALL_STAT_EN
    logic        stall_cnt_clr;
    logic [15:0] stall_cnt;
`endif

    zclock_gen_if #(.SPD_W(2), .WAIT_W(4)) bus ();

    zclock_gen #(
        .SPD_MAX    (2),
        .SPD_W      (2),
        .WAIT_W     (4),
        .IO_SPD_MIN (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ZCLOCK_STALL_STAT_EN
        ,
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until zclk_out changes level (bounded).
    task automatic wait_edge();
        logic start;
        int   n;
        start = bus.zclk_out;
        n     = 0;
        do begin
            tick();
            n++;
        end while (bus.zclk_out === start && n < 40);
        chk("edge_timeout", int'(n < 40), 1);
    endtask

    // Length in clk cycles of the next full zclk_out half-period.
    task automatic measure_half(output int len);
        logic lvl;
        wait_edge();
        lvl = bus.zclk_out;
        len = 0;
        do begin
            tick();
            len++;
        end while (bus.zclk_out === lvl && len < 40);
    endtask

    // Falling rfsh_n edge with the given request; spd_cur is updated on return.
    task automatic rfsh_fall(input logic [1:0] req);
        bus.spd_req = req;
        tick();
        bus.rfsh_n = 1'b0;
        tick();
        bus.rfsh_n = 1'b1;
    endtask

    // Strobe(s) already driven and settled: count stall cycles over n samples.
    task automatic run_stall(input int n, output int hi);
        hi = int'(bus.stall);
        tick();
        bus.iorq_s   = 1'b0;
        bus.dos_on   = 1'b0;
        bus.vdos_off = 1'b0;
        #1;
        if (bus.stall) hi++;
        for (int i = 2; i < n; i++) begin
            tick();
            if (bus.stall) hi++;
        end
    endtask

    initial begin
        int len;
        int hi;
        int n;
        int strobes;

        rst_n             = 1'b0;
        bus.spd_req       = 2'd0;
        bus.rfsh_n        = 1'b1;
        bus.iorq_s        = 1'b0;
        bus.external_port = 1'b0;
        bus.dos_on        = 1'b0;
        bus.vdos_off      = 1'b0;
        bus.cpu_stall     = 1'b0;
        bus.ide_stall     = 1'b0;
        bus.dos_wait      = 4'(DOS_WAIT_DEF);
        bus.io_wait       = 4'(IO_WAIT_DEF);
`ifdef ZCLOCK_STALL_STAT_EN
        stall_cnt_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_zclk",  bus.zclk_out, 0);
        chk("rst_zpos",  bus.zpos,     0);
        chk("rst_zneg",  bus.zneg,     0);
        chk("rst_spd",   bus.spd_cur,  0);
        chk("rst_stall", bus.stall,    0);

        rst_n = 1'b1;
        tick();

        // Speed 2: rfsh fall, spd_cur two cycles later, clock toggles every clk.
        bus.spd_req = 2'(SPD_14M);
        bus.rfsh_n  = 1'b0;
        tick();
        bus.rfsh_n  = 1'b1;
        tick();
        chk("spd_cur_14m", bus.spd_cur, 2);
        n = 0;
        while (bus.zneg !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("sync_zneg", int'(n < 20), 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fast_zneg[%0d]", i), bus.zneg,     int'(i % 2 == 0));
            chk($sformatf("fast_zpos[%0d]", i), bus.zpos,     int'(i % 2 == 1));
            chk($sformatf("fast_zclk[%0d]", i), bus.zclk_out, int'(i % 2 == 1));
            tick();
        end

        // Request change without rfsh edge is ignored.
        bus.spd_req = 2'(SPD_3M5);
        repeat (6) tick();
        chk("spd_hold", bus.spd_cur, 2);
        measure_half(len);
        chk("hp_still_fast", len, 1);

        // rfsh fall: transition to 3.5 MHz, no half-period longer than 4.
        bus.rfsh_n = 1'b0;
        tick();
        bus.rfsh_n = 1'b1;
        chk("spd_cur_3m5", bus.spd_cur, 0);
        for (int i = 0; i < 3; i++) begin
            measure_half(len);
            chk($sformatf("trans_hp_in_range[%0d]", i), int'(len >= 1 && len <= 4), 1);
        end
        chk("hp_3m5", len, 4);

        // cpu_stall for 3 cycles mid-phase stretches the half-period to 7.
        wait_edge();
        tick();
        bus.cpu_stall = 1'b1;
        tick();
        chk("cpu_stall_out", bus.stall, 1);
        tick();
        tick();
        bus.cpu_stall = 1'b0;
        n = 4;
        begin
            logic lvl;
            lvl = bus.zclk_out;
            do begin
                tick();
                n++;
            end while (bus.zclk_out === lvl && n < 40);
        end
        chk("hp_stretched", n, 7);

        // Speed 1: half-period 2, external IO not stalled.
        rfsh_fall(2'(SPD_7M));
        chk("spd_cur_7m", bus.spd_cur, 1);
        measure_half(len);
        measure_half(len);
        chk("hp_7m", len, 2);
        bus.iorq_s        = 1'b1;
        bus.external_port = 1'b1;
        #1;
        chk("io_nostall_start", bus.stall, 0);
        tick();
        bus.iorq_s = 1'b0;
        #1;
        chk("io_nostall_after", bus.stall, 0);

        // Out-of-range request clamps to SPD_MAX.
        rfsh_fall(2'd3);
        chk("spd_clamp", bus.spd_cur, 2);
        repeat (3) tick();

        // External IO at speed 2: 9 stall cycles, clock frozen.
        bus.iorq_s = 1'b1;
        #1;
        chk("io_stall_start", bus.stall, 1);
        hi = 1;
        strobes = 0;
        tick();
        bus.iorq_s = 1'b0;
        #1;
        for (int i = 1; i < 12; i++) begin
            if (i > 1) tick();
            if (bus.stall) hi++;
            if (i <= 9 && (bus.zpos || bus.zneg)) strobes++;
        end
        chk("io_stall_len", hi, 9);
        chk("io_strobes_frozen", strobes, 0);

        // DOS and IO together: DOS wins, 5 stall cycles.
        bus.dos_on = 1'b1;
        bus.iorq_s = 1'b1;
        #1;
        run_stall(14, hi);
        chk("dos_wins_len", hi, 5);

        // IO start, then DOS 3 cycles later reloads (no accumulation): 3 + 1 + 4.
        bus.iorq_s = 1'b1;
        #1;
        hi = 1;
        tick();
        bus.iorq_s = 1'b0;
        #1;
        if (bus.stall) hi++;
        tick();
        if (bus.stall) hi++;
        tick();
        bus.dos_on = 1'b1;
        #1;
        if (bus.stall) hi++;
        tick();
        bus.dos_on = 1'b0;
        #1;
        if (bus.stall) hi++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.stall) hi++;
        end
        chk("reload_len", hi, 8);

        // Zero wait length: only the start cycle stalls.
        bus.dos_wait = 4'd0;
        bus.vdos_off = 1'b1;
        #1;
        run_stall(6, hi);
        chk("zero_wait_len", hi, 1);
        bus.dos_wait = 4'(DOS_WAIT_DEF);

        bus.ide_stall = 1'b1;
        #1;
        chk("ide_stall_out", bus.stall, 1);
        tick();
        bus.ide_stall = 1'b0;
        #1;
        chk("ide_stall_clear", bus.stall, 0);

        // Reset asserted mid-stall at speed 2.
        bus.iorq_s = 1'b1;
        tick();
        bus.iorq_s = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", bus.stall,    0);
        chk("midrst_spd",   bus.spd_cur,  0);
        chk("midrst_zclk",  bus.zclk_out, 0);
        chk("midrst_zpos",  bus.zpos,     0);
        chk("midrst_zneg",  bus.zneg,     0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef ZCLOCK_STALL_STAT_EN
        chk("stat_reset", stall_cnt, 0);
        bus.ide_stall = 1'b1;
        repeat (10) tick();
        bus.ide_stall = 1'b0;
        chk("stat_count", stall_cnt, 10);
        tick();
        chk("stat_hold", stall_cnt, 10);
        bus.ide_stall = 1'b1;
        stall_cnt_clr = 1'b1;
        tick();
        chk("stat_clear", stall_cnt, 0);
        bus.ide_stall = 1'b0;
        stall_cnt_clr = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
